// File: rtl/nn_pkg.sv
// nn_pkg: shared defaults and output-stage FSM states for the vector scaler datapath
package nn_pkg;
    localparam int NN_WIDTH = 8;
    localparam int NN_SIZE = 6;
    localparam int NN_ACC = 3;
    typedef enum logic [1:0] {IDLE = 2'd0, CAPT = 2'd1, HOLD = 2'd2} act_state_t;
endpackage

// File: rtl/act_lane.sv
// act_lane: one lane of ReLU, round-half-up right shift and saturation (combinational)
// VSM_ACT_RELU_EN defined applies ReLU; undefined keeps the lane signed end to end.
module act_lane #(
    parameter int WIDTH = 8,
    parameter int SHIFT = 0
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] z
);
    localparam logic signed [WIDTH:0] RND = (WIDTH+1)'((1 << SHIFT) >> 1);
    localparam logic signed [WIDTH:0] MAX = (WIDTH+1)'((1 << (WIDTH-1)) - 1);
`ifdef VSM_ACT_RELU_EN
    localparam logic signed [WIDTH:0] MIN = '0;
`else
    localparam logic signed [WIDTH:0] MIN = -MAX - (WIDTH+1)'(1);
`endif
    logic signed [WIDTH:0] y, s;
    // One guard bit keeps the rounding add from wrapping before the shift.
    always_comb begin
`ifdef VSM_ACT_RELU_EN
        y = x[WIDTH-1] ? '0 : {1'b0, x};
`else
        y = {x[WIDTH-1], x};
`endif
        s = (y + RND) >>> SHIFT;
        z = s > MAX ? MAX[WIDTH-1:0] : s < MIN ? MIN[WIDTH-1:0] : s[WIDTH-1:0];
    end
endmodule

// File: rtl/vsm_act_out.sv
// vsm_act_out: counts accumulation enables, captures the settled vector, activates it per lane
// and offers it downstream over valid/ready with a sticky overrun flag (VSM_ACT_RELU_EN selects ReLU).
module vsm_act_out
    import nn_pkg::*;
#(
    parameter int SIZE = NN_SIZE,
    parameter int WIDTH = NN_WIDTH,
    parameter int ACCUMULATIONS = NN_ACC,
    parameter int SHIFT = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [WIDTH*SIZE-1:0] in_vec,
    output logic [WIDTH*SIZE-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  stall,
    output logic                  overrun
);
    localparam int CW = ACCUMULATIONS > 1 ? $clog2(ACCUMULATIONS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ACCUMULATIONS - 1);
    act_state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [WIDTH*SIZE-1:0] lanes;
    logic vld, last, cap, load, drop, vld_n;
    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        act_lane #(.WIDTH(WIDTH), .SHIFT(SHIFT)) u_lane (
            .x(in_vec[WIDTH*i +: WIDTH]),
            .z(lanes[WIDTH*i +: WIDTH])
        );
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            vld <= 1'b0;
            out_data <= '0;
            overrun <= 1'b0;
        end else begin
            state <= nxt;
            cnt <= last ? '0 : cnt + CW'(enable);
            vld <= vld_n;
            if (load) out_data <= lanes;
            if (drop) overrun <= 1'b1;
        end
    end
    // A capture only loads if the slot is empty or is being emptied this cycle.
    always_comb begin
        last = enable && cnt == LAST;
        cap = state == CAPT;
        load = cap && (!vld || out_ready);
        drop = cap && vld && !out_ready;
        vld_n = load || (vld && !out_ready);
        nxt = last ? CAPT : vld_n ? HOLD : IDLE;
    end
    always_comb begin
        out_valid = vld;
        stall = vld && !out_ready;
    end
endmodule

// File: tb/tb_vsm_act_out.sv
// tb_vsm_act_out: directed table and corner-case sequences for vsm_act_out
// Three SHIFT variants (0,1,2) with ACCUMULATIONS=3 plus one ACCUMULATIONS=1 instance share stimulus.
module tb_vsm_act_out;
    typedef struct packed {
        logic [47:0] vec;
        logic [2:0][47:0] e;
    } vec_t;

    logic clk = 1'b0;
    logic reset, enable, out_ready;
    logic [47:0] in_vec;
    logic [47:0] od [4];
    logic ov [4];
    logic st [4];
    logic orun [4];
    int checks = 0;
    int failures = 0;
    vec_t tbl [4];
    logic [47:0] va, vb, vc, vd;

    always #5 clk = ~clk;

    vsm_act_out #(.SIZE(6), .WIDTH(8), .ACCUMULATIONS(3), .SHIFT(0)) u_s0 (
        .clk(clk), .reset(reset), .enable(enable), .in_vec(in_vec), .out_data(od[0]),
        .out_valid(ov[0]), .out_ready(out_ready), .stall(st[0]), .overrun(orun[0]));
    vsm_act_out #(.SIZE(6), .WIDTH(8), .ACCUMULATIONS(3), .SHIFT(1)) u_s1 (
        .clk(clk), .reset(reset), .enable(enable), .in_vec(in_vec), .out_data(od[1]),
        .out_valid(ov[1]), .out_ready(out_ready), .stall(st[1]), .overrun(orun[1]));
    vsm_act_out #(.SIZE(6), .WIDTH(8), .ACCUMULATIONS(3), .SHIFT(2)) u_s2 (
        .clk(clk), .reset(reset), .enable(enable), .in_vec(in_vec), .out_data(od[2]),
        .out_valid(ov[2]), .out_ready(out_ready), .stall(st[2]), .overrun(orun[2]));
    vsm_act_out #(.SIZE(6), .WIDTH(8), .ACCUMULATIONS(1), .SHIFT(0)) u_a1 (
        .clk(clk), .reset(reset), .enable(enable), .in_vec(in_vec), .out_data(od[3]),
        .out_valid(ov[3]), .out_ready(out_ready), .stall(st[3]), .overrun(orun[3]));

    function automatic logic [47:0] pk(int a0, int a1, int a2, int a3, int a4, int a5);
        return {8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic vec_t mk(logic [47:0] v, logic [47:0] s0, logic [47:0] s1, logic [47:0] s2);
        vec_t r;
        r.vec = v;
        r.e[0] = s0;
        r.e[1] = s1;
        r.e[2] = s2;
        return r;
    endfunction

    task automatic chk(string nm, logic [47:0] act, logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        enable = 1'b0;
        out_ready = 1'b0;
        step;
        step;
        reset = 1'b0;
    endtask

    // Three enables on a steady vector; returns in the capture cycle.
    task automatic group(logic [47:0] v);
        in_vec = v;
        for (int i = 0; i < 3; i++) begin
            enable = 1'b1;
            step;
        end
        enable = 1'b0;
    endtask

    initial begin
        va = pk(5, -3, 127, 0, -128, 64);
        vb = pk(6, 7, -1, 126, 1, 2);
        vc = pk(-3, -128, 5, -1, -2, 127);
        vd = pk(100, -50, 33, -7, 8, 1);
`ifdef VSM_ACT_RELU_EN
        tbl[0] = mk(va, pk(5, 0, 127, 0, 0, 64), pk(3, 0, 64, 0, 0, 32), pk(1, 0, 32, 0, 0, 16));
        tbl[1] = mk(vb, pk(6, 7, 0, 126, 1, 2), pk(3, 4, 0, 63, 1, 1), pk(2, 2, 0, 32, 0, 1));
        tbl[2] = mk(vc, pk(0, 0, 5, 0, 0, 127), pk(0, 0, 3, 0, 0, 64), pk(0, 0, 1, 0, 0, 32));
        tbl[3] = mk(vd, pk(100, 0, 33, 0, 8, 1), pk(50, 0, 17, 0, 4, 1), pk(25, 0, 8, 0, 2, 0));
`else
        tbl[0] = mk(va, pk(5, -3, 127, 0, -128, 64), pk(3, -1, 64, 0, -64, 32), pk(1, -1, 32, 0, -32, 16));
        tbl[1] = mk(vb, pk(6, 7, -1, 126, 1, 2), pk(3, 4, 0, 63, 1, 1), pk(2, 2, 0, 32, 0, 1));
        tbl[2] = mk(vc, pk(-3, -128, 5, -1, -2, 127), pk(-1, -64, 3, 0, -1, 64), pk(-1, -32, 1, 0, 0, 32));
        tbl[3] = mk(vd, pk(100, -50, 33, -7, 8, 1), pk(50, -25, 17, -3, 4, 1), pk(25, -12, 8, -2, 2, 0));
`endif
        in_vec = '0;
        do_reset;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst.valid.d%0d", k), 48'(ov[k]), 48'd0);
            chk($sformatf("rst.data.d%0d", k), od[k], 48'd0);
            chk($sformatf("rst.overrun.d%0d", k), 48'(orun[k]), 48'd0);
            chk($sformatf("rst.stall.d%0d", k), 48'(st[k]), 48'd0);
        end

        for (int i = 0; i < 4; i++) begin
            do_reset;
            group(tbl[i].vec);
            for (int k = 0; k < 3; k++)
                chk($sformatf("tbl%0d.early.d%0d", i, k), 48'(ov[k]), 48'd0);
            step;
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("tbl%0d.valid.d%0d", i, k), 48'(ov[k]), 48'd1);
                chk($sformatf("tbl%0d.data.d%0d", i, k), od[k], tbl[i].e[k]);
                chk($sformatf("tbl%0d.stall.d%0d", i, k), 48'(st[k]), 48'd1);
            end
            out_ready = 1'b1;
            #1;
            chk($sformatf("tbl%0d.stall_rdy", i), 48'(st[0]), 48'd0);
            step;
            for (int k = 0; k < 3; k++)
                chk($sformatf("tbl%0d.drop_valid.d%0d", i, k), 48'(ov[k]), 48'd0);
            out_ready = 1'b0;
        end

        // Two groups with no acceptance: the second is dropped and overrun sticks.
        do_reset;
        group(va);
        step;
        group(vb);
        chk("ovr.before", 48'(orun[0]), 48'd0);
        chk("ovr.stall_held", 48'(st[0]), 48'd1);
        step;
        chk("ovr.set", 48'(orun[0]), 48'd1);
        chk("ovr.valid", 48'(ov[0]), 48'd1);
        chk("ovr.data_kept", od[0], tbl[0].e[0]);
        chk("ovr.stall", 48'(st[0]), 48'd1);
        step;
        chk("ovr.sticky", 48'(orun[0]), 48'd1);
        do_reset;
        chk("ovr.cleared", 48'(orun[0]), 48'd0);

        // Capture coincides with acceptance of the previous result.
        group(va);
        step;
        group(vb);
        out_ready = 1'b1;
        step;
        chk("coin.valid", 48'(ov[0]), 48'd1);
        chk("coin.data", od[0], tbl[1].e[0]);
        chk("coin.data_s2", od[2], tbl[1].e[2]);
        chk("coin.overrun", 48'(orun[0]), 48'd0);
        step;
        chk("coin.drain", 48'(ov[0]), 48'd0);
        out_ready = 1'b0;

        // Reset after two enables with a result still held.
        do_reset;
        group(va);
        step;
        in_vec = vd;
        enable = 1'b1;
        step;
        step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        enable = 1'b0;
        chk("mid.valid", 48'(ov[0]), 48'd0);
        chk("mid.data", od[0], 48'd0);
        chk("mid.stall", 48'(st[0]), 48'd0);
        out_ready = 1'b1;
        begin
            int cnt [3];
            for (int k = 0; k < 3; k++) cnt[k] = 0;
            for (int t = 0; t < 9; t++) begin
                enable = t < 3;
                #1;
                for (int k = 0; k < 3; k++)
                    if (ov[k]) begin
                        cnt[k]++;
                        chk($sformatf("mid.data.d%0d", k), od[k], tbl[3].e[k]);
                    end
                step;
            end
            for (int k = 0; k < 3; k++)
                chk($sformatf("mid.count.d%0d", k), 48'(cnt[k]), 48'd1);
        end
        enable = 1'b0;
        out_ready = 1'b0;

        // ACCUMULATIONS=1: back-to-back enables give one result per cycle.
        do_reset;
        for (int t = 0; t < 7; t++) begin
            enable = t < 4;
            out_ready = 1'b1;
            in_vec = {6{8'(10 * t + 1)}};
            #1;
            chk($sformatf("acc1.valid.t%0d", t), 48'(ov[3]), 48'(t >= 2 && t <= 5));
            if (t >= 2 && t <= 5)
                chk($sformatf("acc1.data.t%0d", t), od[3], {6{8'(10 * (t - 1) + 1)}});
            step;
        end
        chk("acc1.overrun", 48'(orun[3]), 48'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vsm_act_out.md
# vsm_act_out

Output stage directly downstream of the vector scaler multiplier. It monitors the same `enable` stream that drives the multiplier array and counts accumulation steps. Once a full group of `ACCUMULATIONS` steps has settled, it captures the SIZE-lane result vector and applies ReLU and a rounding right-shift per lane. It presents the result to the next layer over a valid/ready handshake and flags overruns.

## Interface
- `SIZE`, 6, number of lanes (must match the multiplier array).
- `WIDTH`, 8, bits per lane, two's-complement on input.
- `ACCUMULATIONS`, 3, enable pulses per result group, ≥1.
- `SHIFT`, 0, right-shift applied per lane after activation, 0..WIDTH-1.

Ports (clock and reset first):
- `clk` input 1: the single clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-high.
- `enable` input 1: same signal that drives the multiplier array; one accumulation step per high cycle.
- `in_vec` input WIDTH*SIZE: multiplier array output; lane i is `[WIDTH*i +: WIDTH]`.
- `out_data` output WIDTH*SIZE: processed vector, same lane packing.
- `out_valid` output 1: `out_data` holds an unaccepted result.
- `out_ready` input 1: downstream accepts when `out_valid && out_ready`.
- `stall` output 1: combinational `out_valid && !out_ready`; upstream may gate `enable` with it.
- `overrun` output 1: sticky; a completed group was dropped.

## Operation
- Step counter `cnt` runs 0..ACCUMULATIONS-1 and increments on each `enable`.
  - On an `enable` with `cnt==ACCUMULATIONS-1`, `cnt` wraps to 0 and `cap_pend` is set for exactly the next cycle.
- States (2-bit FSM):
  - IDLE: no result held.
  - CAPT: `cap_pend` cycle; `in_vec` is final and sampled at the end of this cycle.
  - HOLD: result held, `out_valid=1`.
- Lane function, applied to the signed input x:
  - Activation: y = (x<0) ? 0 : x.
  - Shift: z = (y + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >> SHIFT.
  - Saturate z to 2^(WIDTH-1)-1.
  - The output is non-negative and WIDTH bits.
- Capture while a result is still held:
  - If the held result is accepted in the same cycle (`out_ready=1`), the new result loads and no overrun occurs.
  - Otherwise the new result is dropped, the held data is unchanged, and `overrun` is set.
- `enable` pulses during CAPT or HOLD count toward the next group; counting never stalls.
- `overrun` clears only on `reset`.

## Timing
- Reset values:
  - `out_data`=0, `out_valid`=0, `overrun`=0, `stall`=0.
  - `cnt`=0, FSM in IDLE.
- Latency: the last `enable` is in cycle T.
  - `in_vec` is sampled at the end of T+1.
  - `out_valid` rises in T+2, so result latency is 2 cycles from the last enable.
- `out_valid` and `out_data` are registered and stable until the handshake completes.
- After acceptance at the end of cycle A, `out_valid=0` in A+1 unless a capture occurred in A.
- With ACCUMULATIONS=1, every `enable` produces a result. Back-to-back enables give one result per cycle if `out_ready` is held high.
- `reset` mid-group discards the partial count and any held result. The first group after reset needs a full ACCUMULATIONS enables.
- `reset` has priority over every other event in the same cycle.

## Configuration
- `VSM_ACT_RELU_EN`
  - Defined: the ReLU activation step is applied as specified.
  - Undefined: ReLU is skipped, and shift and saturation operate on the signed value. The shift is arithmetic, and saturation clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1], so the output stays signed.
  - Handshake, counter and overrun behaviour are identical in both builds.

## Structure
- Shared package `nn_pkg`: FSM state typedef (IDLE/CAPT/HOLD), and the default WIDTH/SIZE/ACCUMULATIONS constants shared with the multiplier array.
- One sub-module, `act_lane`: combinational, one WIDTH-bit lane covering activation, rounding shift and saturation, parameterised by WIDTH/SHIFT. It is instanced SIZE times by generate. Registers stay in the top.

## Test plan
- Reset release; ACC=3. Drive 3 enables with `in_vec` lanes = {5,-3,127,0,-128,64}, then `out_ready`=1. Expect `out_valid` 2 cycles after the 3rd enable, `out_data` = {5,0,127,0,0,64}, and deassertion after one cycle.
- SHIFT=2. Lane values {6,7,-1,126,1,2} give {2,2,0,32,0,1}, which checks round-half-up and saturation bounds.
- `out_ready`=0, two complete groups. Expect the first result held, `overrun`=1 one cycle after the second capture, and `stall`=1 throughout.
- A capture coincides with the handshake of the previous result. Expect the new data in the next cycle, `out_valid` staying 1, and `overrun`=0.
- `reset` asserted after 2 of 3 enables. Expect all outputs 0; the following 3 enables produce exactly one result.
- Build without `VSM_ACT_RELU_EN`, SHIFT=1. Lanes {-3,-128,5,...} give {-1,-64,3,...} (signed arithmetic shift with rounding).
